// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, sequencer states and parked-bus constants
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  // Fixed four-step access sequence
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bus value while no access is in flight: read strobe, RAM selected, zero address/data
  localparam logic PARK_RW = 1'b1;
  localparam logic PARK_CS = 1'b0;

  // A write aimed at ROM is never allowed onto the bus as a write
  function automatic logic is_rom_write(input logic rw, input logic cs);
    return cs & ~rw;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant with alternating priority
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_en,
  output logic o_valid,
  output logic o_idx
);

  logic r_prio;

  // Grant the lone requester, or the prio port when both ask
  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 & i_req1) begin
      o_idx = r_prio;
    end else begin
      o_idx = i_req1;
    end
  end

  // Priority moves to the port that lost (or did not take) each grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (i_en && o_valid) begin
      r_prio <= ~o_idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and 4-state access sequencer for the RAM/ROM block
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic              i_rw0,
  input  logic              i_cs0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_rw1,
  input  logic              i_cs1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rw,
  output logic              o_mem_cs,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t              r_state;
  logic                r_gnt;
  logic                r_rom_wr;

  logic                w_arb_en;
  logic                w_gnt_valid;
  logic                w_gnt_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_rw;
  logic                w_cs;
  logic [DATA_W-1:0]   w_wdata;

  assign w_arb_en = (r_state == ST_IDLE);

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req0  (i_req0),
    .i_req1  (i_req1),
    .i_en    (w_arb_en),
    .o_valid (w_gnt_valid),
    .o_idx   (w_gnt_idx)
  );

  // Select the winning requester's transaction fields
  always_comb begin
    w_addr  = w_gnt_idx ? i_addr1  : i_addr0;
    w_rw    = w_gnt_idx ? i_rw1    : i_rw0;
    w_cs    = w_gnt_idx ? i_cs1    : i_cs0;
    w_wdata = w_gnt_idx ? i_wdata1 : i_wdata0;
  end

  // Sequencer: the bus registers double as the transaction latch through BUS and WAIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 1'b0;
      r_rom_wr    <= 1'b0;
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_err0      <= 1'b0;
      o_err1      <= 1'b0;
      o_rdata     <= '0;
      o_mem_addr  <= '0;
      o_mem_rw    <= PARK_RW;
      o_mem_cs    <= PARK_CS;
      o_mem_wdata <= '0;
    end else begin
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      o_err0 <= 1'b0;
      o_err1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt       <= w_gnt_idx;
            r_rom_wr    <= is_rom_write(w_rw, w_cs);
            o_mem_addr  <= w_addr;
            o_mem_rw    <= w_rw | w_cs;
            o_mem_cs    <= w_cs;
            o_mem_wdata <= w_wdata;
            r_state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Write strobe ends here; the same location is read back in WAIT
          o_mem_rw <= 1'b1;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          o_rdata     <= i_mem_rdata;
          o_ack0      <= ~r_gnt;
          o_ack1      <= r_gnt;
          o_err0      <= ~r_gnt & r_rom_wr;
          o_err1      <= r_gnt & r_rom_wr;
          o_mem_addr  <= '0;
          o_mem_rw    <= PARK_RW;
          o_mem_cs    <= PARK_CS;
          o_mem_wdata <= '0;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with RAM/ROM model
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] addr0, addr1;
  logic       rw0, rw1, cs0, cs1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata;
  logic [2:0] mem_addr;
  logic       mem_rw, mem_cs;
  logic [7:0] mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int n_strobe = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req0      (req0),
    .i_addr0     (addr0),
    .i_rw0       (rw0),
    .i_cs0       (cs0),
    .i_wdata0    (wdata0),
    .i_req1      (req1),
    .i_addr1     (addr1),
    .i_rw1       (rw1),
    .i_cs1       (cs1),
    .i_wdata1    (wdata1),
    .o_ack0      (ack0),
    .o_ack1      (ack1),
    .o_err0      (err0),
    .o_err1      (err1),
    .o_rdata     (rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_rw    (mem_rw),
    .o_mem_cs    (mem_cs),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // ROM holds the Fibonacci sequence: 0,1,1,2,3,5,8,13
  function automatic logic [7:0] rom_val(input logic [2:0] a);
    int x = 0;
    int y = 1;
    int t;
    for (int i = 0; i < int'(a); i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x[7:0];
  endfunction

  // Memory block: ROM registered one cycle, RAM read combinational, RAM write on clock
  logic [7:0] ram [8];
  logic [7:0] rom_q;
  always @(posedge clk) begin
    rom_q <= rom_val(mem_addr);
    if (!mem_cs && !mem_rw) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_cs ? rom_q : ram[mem_addr];

  // Count cycles in which the RAM write strobe is asserted
  always @(posedge clk) if (rst_n === 1'b1 && mem_rw === 1'b0) n_strobe++;

  // Reference model state
  logic [7:0] m_ram [8];
  bit         m_prio;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_access(input logic [2:0] a, input logic rw, input logic cs,
                              input logic [7:0] wd, output logic [7:0] rd,
                              output logic err, output int strobes);
    if (cs) begin
      rd = rom_val(a);
      err = !rw;
      strobes = 0;
    end else begin
      if (!rw) m_ram[a] = wd;
      rd = m_ram[a];
      err = 1'b0;
      strobes = rw ? 0 : 1;
    end
  endtask

  task automatic set_port(input bit p, input logic [2:0] a, input logic rw,
                          input logic cs, input logic [7:0] wd);
    if (!p) begin addr0 = a; rw0 = rw; cs0 = cs; wdata0 = wd; end
    else    begin addr1 = a; rw1 = rw; cs1 = cs; wdata1 = wd; end
  endtask

  task automatic wait_ack(output int lat, output bit port);
    bit seen = 0;
    lat = 0;
    port = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        seen = 1;
        port = (ack1 === 1'b1);
      end
    end
    if (!seen) lat = 99;
  endtask

  // Raise the given requests and check ngr grants; cont keeps requests high until the last ack
  task automatic do_run(input bit r0, input bit r1, input int ngr, input bit cont, input string tag);
    bit a0, a1, g, port;
    int lat, estr;
    logic [7:0] erd;
    logic eerr;
    a0 = r0;
    a1 = r1;
    erd = 8'h00;
    n_strobe = 0;
    req0 = r0;
    req1 = r1;
    for (int k = 0; k < ngr; k++) begin
      g = (a0 && a1) ? m_prio : a1;
      if (!g) model_access(addr0, rw0, cs0, wdata0, erd, eerr, estr);
      else    model_access(addr1, rw1, cs1, wdata1, erd, eerr, estr);
      m_prio = ~g;
      wait_ack(lat, port);
      chk({tag, "_latency"}, lat, (k == 0) ? 3 : 4);
      chk({tag, "_port"}, 32'(port), 32'(g));
      chk({tag, "_other_ack"}, 32'(g ? ack0 : ack1), 0);
      chk({tag, "_rdata"}, 32'(rdata), 32'(erd));
      chk({tag, "_err"}, 32'(g ? err1 : err0), 32'(eerr));
      chk({tag, "_other_err"}, 32'(g ? err0 : err1), 0);
      chk({tag, "_strobes"}, n_strobe, estr);
      n_strobe = 0;
      if (!cont || k == ngr - 1) begin
        if (!g) begin a0 = 0; req0 = 0; end
        else    begin a1 = 0; req1 = 0; end
      end
    end
    req0 = 0;
    req1 = 0;
    @(negedge clk);
    chk({tag, "_idle_ack"}, 32'({ack0, ack1, err0, err1}), 0);
    chk({tag, "_idle_bus"}, 32'({mem_addr, mem_rw, mem_cs, mem_wdata}), 32'({3'd0, 1'b1, 1'b0, 8'd0}));
    chk({tag, "_rdata_hold"}, 32'(rdata), 32'(erd));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram[i] = 8'h00;
      m_ram[i] = 8'h00;
    end
    m_prio = 0;
    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    set_port(0, 0, 1, 0, 0);
    set_port(1, 0, 1, 0, 0);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1'($urandom); req1 = 1'($urandom);
      set_port(0, 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      set_port(1, 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      chk("reset_flags", 32'({ack0, ack1, err0, err1}), 0);
      chk("reset_rdata", 32'(rdata), 0);
      chk("reset_bus", 32'({mem_addr, mem_rw, mem_cs, mem_wdata}), 32'({3'd0, 1'b1, 1'b0, 8'd0}));
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // RAM write then read-back on port 0
    set_port(0, 3'd3, 1'b0, 1'b0, 8'hA5);
    do_run(1, 0, 1, 0, "ram_write");
    set_port(0, 3'd3, 1'b1, 1'b0, 8'h00);
    do_run(1, 0, 1, 0, "ram_read");

    // ROM read on port 1
    set_port(1, 3'd5, 1'b1, 1'b1, 8'h00);
    do_run(0, 1, 1, 0, "rom_read");

    // Rejected ROM write on port 0
    set_port(0, 3'd2, 1'b0, 1'b1, 8'hFF);
    do_run(1, 0, 1, 0, "rom_write");

    // Continuous contention: four alternating grants
    set_port(0, 3'd3, 1'b1, 1'b0, 8'h00);
    set_port(1, 3'd7, 1'b1, 1'b1, 8'h00);
    do_run(1, 1, 4, 1, "contend");

    // Randomized traffic against the model
    for (int i = 0; i < 24; i++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      set_port(0, 3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
      set_port(1, 3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
      do_run(r0, r1, int'(r0) + int'(r1), 0, "random");
    end

    // Reset during WAIT of a RAM write: no ack, bus parks, the write stands
    set_port(0, 3'd6, 1'b0, 1'b0, 8'h3C);
    req0 = 1;
    repeat (2) @(negedge clk);
    chk("mid_wait_bus", 32'({mem_addr, mem_rw, mem_cs}), 32'({3'd6, 1'b1, 1'b0}));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_bus", 32'({mem_addr, mem_rw, mem_cs, mem_wdata}), 32'({3'd0, 1'b1, 1'b0, 8'd0}));
    chk("mid_reset_ack", 32'({ack0, ack1, err0, err1}), 0);
    m_ram[6] = 8'h3C;
    m_prio = 0;
    req0 = 0;
    @(negedge clk);
    chk("mid_reset_noack", 32'({ack0, ack1}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    set_port(0, 3'd6, 1'b1, 1'b0, 8'h00);
    set_port(1, 3'd6, 1'b1, 1'b0, 8'h00);
    do_run(1, 1, 2, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
